// File: rtl/port_alloc_rr.sv
// port_alloc_rr -- one-cycle round-robin output-port allocator for a
// NUM_PORT-port bufferless router. Inputs are served starting at prioPtr;
// each valid input takes the lowest-index free output in its productive mask.
// Optional feature macro: DEFLECT_EN -- when defined, inputs left without a
// productive output are deflected onto the lowest remaining free output.
module port_alloc_rr #(
  parameter int NUM_PORT     = 6,
  parameter int LOG_NUM_PORT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [NUM_PORT-1:0]          reqValid,
  input  logic [NUM_PORT*NUM_PORT-1:0] reqPort,
  output logic [NUM_PORT*NUM_PORT-1:0] allocVector,
  output logic [NUM_PORT-1:0]          grantValid,
  output logic [NUM_PORT-1:0]          deflected,
  output logic [LOG_NUM_PORT-1:0]      prioPtr
);

  logic [NUM_PORT*NUM_PORT-1:0] nextAlloc;
  logic [NUM_PORT-1:0]          nextGrant;
  logic [NUM_PORT-1:0]          freeOut;
  logic [NUM_PORT-1:0]          avail;
  logic [NUM_PORT-1:0]          pick;
  logic [LOG_NUM_PORT-1:0]      ptrNext;
`ifdef DEFLECT_EN
  logic [NUM_PORT-1:0]          nextDefl;
`endif

  // Input served in rotating slot k, given the current priority pointer.
  function automatic int rotIdx(input logic [LOG_NUM_PORT-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    return (s >= NUM_PORT) ? s - NUM_PORT : s;
  endfunction

  // Combinational allocation: productive pass, then optional deflection pass.
  always_comb begin
    // NOTE: every variable gets a default before the loops so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    freeOut   = '1;
    nextAlloc = '0;
    avail     = '0;
    pick      = '0;
`ifdef DEFLECT_EN
    nextDefl  = '0;
`endif
    for (int k = 0; k < NUM_PORT; k++) begin
      for (int i = 0; i < NUM_PORT; i++) begin
        if (i == rotIdx(prioPtr, k)) begin
          avail = reqPort[i*NUM_PORT +: NUM_PORT] & freeOut & {NUM_PORT{reqValid[i]}};
          pick  = avail & (~avail + 1'b1);  // isolate lowest set bit
          nextAlloc[i*NUM_PORT +: NUM_PORT] = pick;
          freeOut = freeOut & ~pick;
        end
      end
    end
`ifdef DEFLECT_EN
    for (int k = 0; k < NUM_PORT; k++) begin
      for (int i = 0; i < NUM_PORT; i++) begin
        if (i == rotIdx(prioPtr, k)) begin
          avail = freeOut & {NUM_PORT{reqValid[i] & ~(|nextAlloc[i*NUM_PORT +: NUM_PORT])}};
          pick  = avail & (~avail + 1'b1);
          nextAlloc[i*NUM_PORT +: NUM_PORT] = nextAlloc[i*NUM_PORT +: NUM_PORT] | pick;
          nextDefl[i] = |pick;
          freeOut = freeOut & ~pick;
        end
      end
    end
`endif
    for (int i = 0; i < NUM_PORT; i++) begin
      nextGrant[i] = |nextAlloc[i*NUM_PORT +: NUM_PORT];
    end
    ptrNext = (prioPtr == LOG_NUM_PORT'(NUM_PORT - 1)) ? '0 : prioPtr + 1'b1;
  end

  // Register the allocation; advance priority only when someone requested.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (reset) begin
      allocVector <= '0;
      grantValid  <= '0;
      prioPtr     <= '0;
    end else if (en) begin
      allocVector <= nextAlloc;
      grantValid  <= nextGrant;
      if (|reqValid) prioPtr <= ptrNext;
    end
  end

`ifdef DEFLECT_EN
  // Deflection flags follow the same reset/enable rules as the grants.
  always_ff @(posedge clk) begin
    if (reset)   deflected <= '0;
    else if (en) deflected <= nextDefl;
  end
`else
  assign deflected = '0;
`endif

endmodule

// File: tb/tb_port_alloc_rr.sv
// tb_port_alloc_rr -- directed and random checks of port_alloc_rr against an
// owner-per-output reference model. Honours DEFLECT_EN like the design.
module tb_port_alloc_rr;

  logic        clk = 1'b0;
  logic        reset, en;
  logic [5:0]  reqValid;
  logic [35:0] reqPort;
  logic [35:0] allocVector;
  logic [5:0]  grantValid, deflected;
  logic [2:0]  prioPtr;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [35:0] mAlloc;
  logic [5:0]  mGrant, mDefl;
  int          mPtr;

  port_alloc_rr dut (
    .clk(clk), .reset(reset), .en(en), .reqValid(reqValid), .reqPort(reqPort),
    .allocVector(allocVector), .grantValid(grantValid), .deflected(deflected),
    .prioPtr(prioPtr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference allocation: walk inputs in priority order, tracking which input
  // owns each output; deflection pass ignores masks.
  task automatic model(input int ptr, input logic [5:0] v, input logic [35:0] p,
                       output logic [35:0] a, output logic [5:0] g, output logic [5:0] d);
    int owner[6];
    bit done[6];
    a = '0; g = '0; d = '0;
    for (int j = 0; j < 6; j++) begin owner[j] = -1; done[j] = 0; end
    for (int k = 0; k < 6; k++) begin
      int i = (ptr + k) % 6;
      if (v[i])
        for (int j = 0; j < 6; j++)
          if (!done[i] && p[i*6+j] && owner[j] < 0) begin owner[j] = i; done[i] = 1; end
    end
`ifdef DEFLECT_EN
    for (int k = 0; k < 6; k++) begin
      int i = (ptr + k) % 6;
      if (v[i] && !done[i])
        for (int j = 0; j < 6; j++)
          if (!done[i] && owner[j] < 0) begin owner[j] = i; done[i] = 1; d[i] = 1'b1; end
    end
`endif
    for (int j = 0; j < 6; j++)
      if (owner[j] >= 0) begin a[owner[j]*6+j] = 1'b1; g[owner[j]] = 1'b1; end
  endtask

  // Apply one cycle of stimulus, advance the model, sample #1 after the edge.
  task automatic tick(input logic e, input logic r, input logic [5:0] v, input logic [35:0] p);
    logic [35:0] a;
    logic [5:0]  g, d;
    en = e; reset = r; reqValid = v; reqPort = p;
    if (r) begin
      mAlloc = '0; mGrant = '0; mDefl = '0; mPtr = 0;
    end else if (e) begin
      model(mPtr, v, p, a, g, d);
      mAlloc = a; mGrant = g; mDefl = d;
      if (|v) mPtr = (mPtr + 1) % 6;
    end
    @(posedge clk);
    #1;
    check("allocVector", 64'(allocVector), 64'(mAlloc));
    check("grantValid",  64'(grantValid),  64'(mGrant));
    check("deflected",   64'(deflected),   64'(mDefl));
    check("prioPtr",     64'(prioPtr),     64'(mPtr));
  endtask

  function automatic logic [35:0] mask(input int i, input logic [5:0] m);
    logic [35:0] r;
    r = '0;
    r[i*6 +: 6] = m;
    return r;
  endfunction

  initial begin
    logic [35:0] p;
    logic [5:0]  cov;
    int          ones;
    en = 1'b0; reset = 1'b1; reqValid = '0; reqPort = '0;
    mAlloc = '0; mGrant = '0; mDefl = '0; mPtr = 0;

    // Reset with requests present: discarded
    tick(1'b1, 1'b1, 6'h3f, '1);
    check("reset_ptr", 64'(prioPtr), 64'd0);

    // Single request, input 0 to output 2
    tick(1'b1, 1'b0, 6'b000001, mask(0, 6'b000100));
    check("single_alloc", 64'(allocVector), 64'h4);
    check("single_grant", 64'(grantValid), 64'h1);
    check("single_ptr", 64'(prioPtr), 64'd1);

    // Contention at prioPtr=0
    tick(1'b1, 1'b1, 6'h0, '0);
    tick(1'b1, 1'b0, 6'b001001, mask(0, 6'b000010) | mask(3, 6'b000010));
`ifdef DEFLECT_EN
    check("contend0_alloc", 64'(allocVector), 64'h2 | (64'h1 << 18));
    check("contend0_defl", 64'(deflected), 64'b001000);
`else
    check("contend0_alloc", 64'(allocVector), 64'h2);
    check("contend0_grant", 64'(grantValid), 64'b000001);
`endif

    // Contention at prioPtr=3
    tick(1'b1, 1'b1, 6'h0, '0);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 6'b000001, mask(0, 6'b000001));
    check("ptr_at3", 64'(prioPtr), 64'd3);
    tick(1'b1, 1'b0, 6'b001001, mask(0, 6'b000010) | mask(3, 6'b000010));
`ifdef DEFLECT_EN
    check("contend3_alloc", 64'(allocVector), (64'h1 << 19) | 64'h1);
    check("contend3_defl", 64'(deflected), 64'b000001);
`else
    check("contend3_alloc", 64'(allocVector), 64'h1 << 19);
`endif

    // Full load: permutation every cycle, pointer walks 0..5,0
    tick(1'b1, 1'b1, 6'h0, '0);
    for (int k = 0; k < 7; k++) begin
      check("full_ptr_before", 64'(prioPtr), 64'(k % 6));
      tick(1'b1, 1'b0, 6'h3f, '1);
      cov = '0; ones = 0;
      for (int i = 0; i < 6; i++) cov = cov | allocVector[i*6 +: 6];
      for (int b = 0; b < 36; b++) ones += int'(allocVector[b]);
      check("full_cover", 64'(cov), 64'h3f);
      check("full_count", 64'(ones), 64'd6);
    end

    // Hold with en=0 and changing requests, then reset under en=1
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 6'($urandom), {$urandom, $urandom});
    tick(1'b1, 1'b1, 6'h3f, '1);
    check("reset_alloc", 64'(allocVector), 64'h0);

    // Empty mask on input 2
    tick(1'b1, 1'b0, 6'b000100, '0);
`ifdef DEFLECT_EN
    check("zero_mask_alloc", 64'(allocVector), 64'h1 << 12);
    check("zero_mask_defl", 64'(deflected), 64'b000100);
`else
    check("zero_mask_grant", 64'(grantValid), 64'h0);
`endif

    // No requests: outputs clear, pointer holds
    tick(1'b1, 1'b0, 6'h0, '1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      p = {$urandom, $urandom} & {$urandom, $urandom};
      tick(($urandom_range(0, 7) != 0), ($urandom_range(0, 40) == 0),
           6'($urandom), p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/port_alloc_rr.md
PORT_ALLOC_RR -- requirements
Module: port_alloc_rr

Interface
REQ-001 NUM_PORT, 6, number of router ports (bypass plus five link ports), taken from global.v.
REQ-002 LOG_NUM_PORT, 3, width of one port index, taken from global.v.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  stage advance; when low, all state and outputs hold.
REQ-006 reqValid  input  NUM_PORT  bit i high: input i holds a flit this cycle.
REQ-007 reqPort  input  NUM_PORT*NUM_PORT  slice [i*NUM_PORT +: NUM_PORT] is input i's productive-output mask (multi-hot allowed).
REQ-008 allocVector  output  NUM_PORT*NUM_PORT  registered; bit [i*NUM_PORT+j] high means input i is granted output j; drives the crossbar control directly.
REQ-009 grantValid  output  NUM_PORT  registered; bit i high when input i holds any grant.
REQ-010 deflected  output  NUM_PORT  registered; bit i high when input i's grant is outside its productive mask.
REQ-011 prioPtr  output  LOG_NUM_PORT  current highest-priority input index, 0..NUM_PORT-1.

Function
REQ-012 Allocation latency is exactly one cycle: requests sampled on the edge where en=1 produce their grants on allocVector/grantValid/deflected in the following cycle.
REQ-013 Inputs are served in rotating order prioPtr, prioPtr+1, ... modulo NUM_PORT; each served valid input takes the lowest-index free output within its productive mask.
REQ-014 Each output is granted to at most one input, and each input receives at most one output, in every cycle.
REQ-015 reqPort bits of inputs with reqValid=0 are ignored; such inputs never receive a grant.
REQ-016 A valid input whose productive outputs are all taken, or whose mask is all-zero, is handled per REQ-023/REQ-024.
REQ-017 On an en=1 edge with at least one reqValid bit set, prioPtr advances by one; 5 wraps to 0.
REQ-018 On an en=1 edge with reqValid all zero, prioPtr holds, and allocVector, grantValid and deflected load all zeros.
REQ-019 When en=0, allocVector, grantValid, deflected and prioPtr hold their previous values regardless of requests.
REQ-020 grantValid[i] equals the OR of allocVector slice i; deflected[i] implies grantValid[i].

Reset
REQ-021 When reset=1 at a rising edge: allocVector=0, grantValid=0, deflected=0 and prioPtr=0, regardless of en and requests.
REQ-022 Reset takes priority over en; requests presented on the reset edge are discarded, and normal allocation resumes on the first edge with reset=0.

Configuration
REQ-023 With DEFLECT_EN defined: after all productive allocation, each still-ungranted valid input is assigned, in the same rotating order, the lowest-index remaining free output, and its deflected bit is set; every valid input is then granted because there are NUM_PORT outputs.
REQ-024 Without DEFLECT_EN: unsatisfied valid inputs receive no grant, grantValid=0 for them, and deflected is held at constant zero.

Verification
REQ-025 Reset, then en=1, reqValid=6'b000001, input 0 mask=6'b000100 -> next cycle allocVector bit 2 set only, grantValid=6'b000001, deflected=0, prioPtr=1.
REQ-026 prioPtr=0; inputs 0 and 3 valid, both with mask 6'b000010 -> input 0 gets output 1; with DEFLECT_EN, input 3 gets output 0 with deflected[3]=1; without DEFLECT_EN, grantValid=6'b000001.
REQ-027 Same requests as REQ-026 with prioPtr=3 -> input 3 gets output 1; input 0 is deflected to output 0 (DEFLECT_EN), confirming the rotation order.
REQ-028 All six inputs valid, all masks 6'b111111, over 7 consecutive en=1 cycles -> every cycle a full permutation, prioPtr sequence 0,1,2,3,4,5,0, no deflections.
REQ-029 en=0 for 3 cycles with changing requests -> outputs and prioPtr unchanged; reset=1 during en=1 with valid requests -> all outputs 0 and prioPtr=0 the next cycle.
REQ-030 Input 2 valid with mask 0, DEFLECT_EN defined, no other requests -> output 0 granted to input 2, deflected[2]=1.
